alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv_pkg.sv | 53 +++++
 rtl/alu_muldiv_div_core.sv | 52 +++++
 rtl/alu_muldiv.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// common holds machine-wide constants, pipes holds execute-stage types.
package common;

    localparam int MULDIV_ITERS = 64;

    typedef logic [63:0] word_t;

    function automatic word_t sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

endpackage

package pipes;

    typedef enum logic [3:0] {
        OP_MUL,
        OP_MULW,
        OP_DIV,
        OP_DIVU,
        OP_REM,
        OP_REMU,
        OP_DIVW,
        OP_DIVUW,
        OP_REMW,
        OP_REMUW
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } muldiv_state_t;

    typedef struct packed {
        logic is_mul;
        logic is_w;
        logic is_sgn;
        logic is_rem;
    } muldiv_dec_t;

    function automatic muldiv_dec_t muldiv_decode(input muldiv_op_t op);
        muldiv_dec_t d;
        d.is_mul = op inside {OP_MUL, OP_MULW};
        d.is_w   = op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
        d.is_sgn = op inside {OP_MULW, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        d.is_rem = op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
        return d;
    endfunction

endpackage

// File: rtl/alu_muldiv_div_core.sv
// Restoring radix-2 divider on unsigned magnitudes, one step per cycle.
// The subtraction is done by the shared adder in the parent.
module div_core
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  word_t       dividend,
    input  word_t       divisor,
    input  logic [65:0] diff,
    output logic [64:0] rs,
    output word_t       d,
    output word_t       q_next,
    output word_t       r_next
);

    word_t q_q;
    word_t r_q;
    word_t d_q;
    logic  ge;
    logic  unused_diff;

    // Trial step: shift the next dividend bit in, keep the difference if
    // it did not borrow, otherwise restore the shifted remainder.
    always_comb begin
        rs          = {r_q, q_q[63]};
        d           = d_q;
        ge          = ~diff[65];
        q_next      = {q_q[62:0], ge};
        r_next      = ge ? diff[63:0] : rs[63:0];
        unused_diff = diff[64];
    end

    // Quotient/remainder/divisor registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= '0;
            r_q <= '0;
            d_q <= '0;
        end else if (load) begin
            q_q <= dividend;
            r_q <= '0;
            d_q <= divisor;
        end else if (step) begin
            q_q <= q_next;
            r_q <= r_next;
        end
    end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative 64-bit multiply/divide unit for the execute stage.
// Shift-add multiply and FSM live here; division steps live in div_core.
module alu_muldiv
    import common::*;
    import pipes::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid,
    input  muldiv_op_t op,
    input  word_t      srca,
    input  word_t      srcb,
    input  logic       flush,
    output logic       ready,
    output logic       done,
    output word_t      result
);

    localparam int            CW   = $clog2(MULDIV_ITERS);
    localparam logic [CW-1:0] LAST = CW'(MULDIV_ITERS - 1);

    muldiv_state_t state_q;
    muldiv_state_t state_d;
    logic [CW-1:0] cnt_q;
    word_t         acc_q;
    word_t         mcand_q;
    word_t         mplier_q;
    logic          w_q;
    logic          rem_q;
    logic          negq_q;
    logic          negr_q;

    muldiv_dec_t   dec;
    word_t         a_ext;
    word_t         b_ext;
    word_t         a_mag;
    word_t         b_mag;
    word_t         min_neg;
    word_t         bypass_res;
    logic          sa;
    logic          sb;
    logic          div_zero;
    logic          div_ovf;
    logic          accept;
    logic          last;
    logic          enter_done;

    logic [65:0]   add_x;
    logic [65:0]   add_y;
    logic [65:0]   add_sum;
    logic          add_cin;

    logic [64:0]   div_rs;
    word_t         div_d;
    word_t         div_q_next;
    word_t         div_r_next;
    word_t         q_fin;
    word_t         r_fin;
    word_t         iter_res;

    // Operand extension, magnitudes and the single-cycle special cases.
    always_comb begin
        dec   = muldiv_decode(op);
        a_ext = srca;
        b_ext = srcb;
        if (dec.is_w) begin
            a_ext = dec.is_sgn ? sext32(srca[31:0]) : {32'b0, srca[31:0]};
            b_ext = dec.is_sgn ? sext32(srcb[31:0]) : {32'b0, srcb[31:0]};
        end
        sa       = dec.is_sgn & a_ext[63];
        sb       = dec.is_sgn & b_ext[63];
        a_mag    = sa ? -a_ext : a_ext;
        b_mag    = sb ? -b_ext : b_ext;
        min_neg  = dec.is_w ? 64'hFFFF_FFFF_8000_0000
                            : 64'h8000_0000_0000_0000;
        div_zero = ~dec.is_mul & (b_ext == '0);
        div_ovf  = ~dec.is_mul & dec.is_sgn
                 & (a_ext == min_neg) & (b_ext == '1);
        if (div_zero) begin
            bypass_res = dec.is_rem ? a_ext : '1;
        end else begin
            bypass_res = dec.is_rem ? '0 : a_ext;
        end
        if (dec.is_w) begin
            bypass_res = sext32(bypass_res[31:0]);
        end
    end

    assign accept = (state_q == IDLE) & valid & ~flush;
    assign last   = (cnt_q == LAST);

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec.is_mul) begin
                        state_d = MUL;
                    end else if (div_zero | div_ovf) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    assign enter_done = (state_d == DONE) & (state_q != DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration counter, running only while multiplying or dividing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (flush || !(state_q == MUL || state_q == DIV)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The one wide adder: accumulate in MUL, trial-subtract in DIV.
    always_comb begin
        add_x   = {2'b0, acc_q};
        add_y   = mplier_q[0] ? {2'b0, mcand_q} : '0;
        add_cin = 1'b0;
        if (state_q == DIV) begin
            add_x   = {1'b0, div_rs};
            add_y   = ~{2'b0, div_d};
            add_cin = 1'b1;
        end
        add_sum = add_x + add_y + {65'b0, add_cin};
    end

    // Shift-add multiplier registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            acc_q    <= '0;
            mcand_q  <= a_ext;
            mplier_q <= b_ext;
        end else if (state_q == MUL) begin
            acc_q    <= add_sum[63:0];
            mcand_q  <= {mcand_q[62:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[63:1]};
        end
    end

    // Per-operation result shaping captured at accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q    <= 1'b0;
            rem_q  <= 1'b0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
        end else if (accept) begin
            w_q    <= dec.is_w;
            rem_q  <= dec.is_rem;
            negq_q <= sa ^ sb;
            negr_q <= sa;
        end
    end

    div_core u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (state_q == DIV),
        .dividend (a_mag),
        .divisor  (b_mag),
        .diff     (add_sum),
        .rs       (div_rs),
        .d        (div_d),
        .q_next   (div_q_next),
        .r_next   (div_r_next)
    );

    // Final-iteration result with signs and W narrowing applied.
    always_comb begin
        q_fin = negq_q ? -div_q_next : div_q_next;
        r_fin = negr_q ? -div_r_next : div_r_next;
        if (state_q == MUL) begin
            iter_res = add_sum[63:0];
        end else begin
            iter_res = rem_q ? r_fin : q_fin;
        end
        if (w_q) begin
            iter_res = sext32(iter_res[31:0]);
        end
    end

    // Result register, loaded only on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result <= '0;
        end else if (enter_done) begin
            result <= (state_q == IDLE) ? bypass_res : iter_res;
        end
    end

    assign ready = (state_q == IDLE);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv.
// Hand-computed vectors covering latency, special cases, flush and reset.
module tb_alu_muldiv;
    import common::*;
    import pipes::*;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       valid = 1'b0;
    logic       flush = 1'b0;
    muldiv_op_t op    = OP_MUL;
    word_t      srca  = '0;
    word_t      srcb  = '0;
    logic       ready;
    logic       done;
    word_t      result;

    int    n_chk    = 0;
    int    n_fail   = 0;
    int    done_cnt = 0;
    int    d0       = 0;
    word_t last_exp = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done) done_cnt++;
    end

    alu_muldiv dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input muldiv_op_t o,
                       input word_t a, input word_t b, input word_t exp,
                       input int exp_lat, input bit poke);
        int n;
        chk({tag, " ready_before"}, 64'(ready), 64'd1);
        op    = o;
        srca  = a;
        srcb  = b;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        op    = OP_MUL;
        srca  = 64'hDEAD_BEEF_0BAD_F00D;
        srcb  = 64'h0123_4567_89AB_CDEF;
        n = 1;
        while (!done && n < 200) begin
            if (poke && n == 3) begin
                valid = 1'b1;
                op    = OP_DIVU;
                srcb  = '0;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        valid = 1'b0;
        chk({tag, " latency"}, 64'(n), 64'(exp_lat));
        chk({tag, " result"}, result, exp);
        last_exp = exp;
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, " ready_after"}, 64'(ready), 64'd1);
        chk({tag, " result_held"}, result, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset done", 64'(done), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset ready", 64'(ready), 64'd1);

        run("mul_7x-3", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
            64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b0);
        run("div_-20/3", OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
            64'hFFFF_FFFF_FFFF_FFFA, 65, 1'b0);
        run("rem_-20%3", OP_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3,
            64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run("remu_20%3", OP_REMU, 64'd20, 64'd3, 64'd2, 65, 1'b0);
        run("divu_20/3", OP_DIVU, 64'd20, 64'd3, 64'd6, 65, 1'b0);
        run("divu_by0", OP_DIVU, 64'h1234, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
        run("rem_by0", OP_REM, 64'h1234, 64'd0, 64'h1234, 1, 1'b0);
        run("div_ovf", OP_DIV, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1, 1'b0);
        run("rem_ovf", OP_REM, 64'h8000_0000_0000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 1'b0);
        run("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000,
            64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
        run("mulw_poke", OP_MULW, 64'h0000_0001_7FFF_FFFF, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);
        run("remw_-7%2", OP_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b0);
        run("divuw_sext", OP_DIVUW, 64'h0000_0000_FFFF_FFFE, 64'd1,
            64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b0);
        run("remuw_by0", OP_REMUW, 64'h1234_0000_0000_0005, 64'd0,
            64'd5, 1, 1'b0);

        d0    = done_cnt;
        op    = OP_DIVU;
        srca  = 64'd9;
        srcb  = 64'd0;
        valid = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        flush = 1'b0;
        chk("flush_valid ready", 64'(ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_valid no_done", 64'(done_cnt), 64'(d0));
        chk("flush_valid result", result, last_exp);

        op    = OP_DIV;
        srca  = 64'd100;
        srcb  = 64'd7;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        d0    = done_cnt;
        repeat (29) @(posedge clk);
        #1;
        chk("flush busy ready", 64'(ready), 64'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush ready", 64'(ready), 64'd1);
        chk("flush result", result, last_exp);
        repeat (70) @(posedge clk);
        #1;
        chk("flush no_done", 64'(done_cnt), 64'(d0));

        run("divu_after_flush", OP_DIVU, 64'd100, 64'd7, 64'd14, 65, 1'b0);

        op    = OP_MUL;
        srca  = 64'd3;
        srcb  = 64'd5;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        d0    = done_cnt;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midreset result", result, 64'd0);
        chk("midreset ready", 64'(ready), 64'd1);
        repeat (70) @(posedge clk);
        #1;
        chk("midreset no_done", 64'(done_cnt), 64'(d0));

        run("mul_after_reset", OP_MUL, 64'd3, 64'd5, 64'd15, 65, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
